// File: rtl/spi_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile_if
// Bundles the SPI pins and the local register port of spi_slave_regfile.
//   SPI side   : spi_sclk, spi_ss_n, spi_mosi (to slave), spi_miso, spi_miso_oe
//   Status     : status_in, the byte returned while the command byte shifts in
//   Local port : loc_addr, loc_wr, loc_wdata (to slave), loc_rdata (from slave)
//   Write notify: wr_strobe, wr_addr, wr_data, busy (from slave)
//   irq        : present only when SPI_IRQ_EN is defined
// Modports: slave = the register file block, master = whatever drives it.
// ---------------------------------------------------------------------------
interface spi_slave_regfile_if;
  logic       spi_sclk;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] status_in;
  logic [4:0] loc_addr;
  logic       loc_wr;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
`ifdef SPI_IRQ_EN
  logic       irq;
`endif

  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, status_in, loc_addr, loc_wr, loc_wdata,
    output spi_miso, spi_miso_oe, loc_rdata, wr_strobe, wr_addr, wr_data, busy
`ifdef SPI_IRQ_EN
    , output irq
`endif
  );

  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, status_in, loc_addr, loc_wr, loc_wdata,
    input  spi_miso, spi_miso_oe, loc_rdata, wr_strobe, wr_addr, wr_data, busy
`ifdef SPI_IRQ_EN
    , input irq
`endif
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile
// SPI mode-0 (CPOL=0, CPHA=0) responder in front of a 32 x 8 register file.
// SPI pins are oversampled in the clk domain; the fabric gets a synchronous
// local read/write port plus a strobe for every byte the SPI master writes.
//
// Ports
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_slave_regfile_if.slave (SPI pins, status_in, local port,
//                wr_strobe/wr_addr/wr_data, busy, optional irq)
// Parameters
//   AUTOINC : 1 = address steps (mod 32) after every data byte, 0 = fixed
//   SYNC_FF : synchronizer depth on sclk/ss_n/mosi (2..3)
// Optional feature macro: SPI_IRQ_EN -- sticky irq set by each SPI write,
//   cleared by a local write to address 31 (set wins on a tie).
//
// Command byte, MSB first: [7:3] register address, [1] 1=write 0=read.
// ---------------------------------------------------------------------------
module spi_slave_regfile #(
  parameter int AUTOINC = 1,
  parameter int SYNC_FF = 2
) (
  input logic                clk,
  input logic                reset,
  spi_slave_regfile_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t             state, state_next;
  logic [SYNC_FF-1:0] sclk_s, ss_s, mosi_s;
  logic               sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;
  logic [2:0]         bit_cnt;
  logic [6:0]         shift_in;
  logic [7:0]         rx_byte, shift_out;
  logic [4:0]         addr, addr_next;
  logic               dir_wr, active, byte_done, spi_we;
  logic [7:0]         regs [32];
  logic               miso_r, miso_oe_r, busy_r, wr_strobe_r;
  logic [4:0]         wr_addr_r;
  logic [7:0]         wr_data_r, loc_rdata_r;

  // Synchronizers; ss_n rests high so leaving reset never looks like a select.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s <= '0;
      ss_s   <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[SYNC_FF-2:0], bus.spi_sclk};
      ss_s   <= {ss_s[SYNC_FF-2:0], bus.spi_ss_n};
      mosi_s <= {mosi_s[SYNC_FF-2:0], bus.spi_mosi};
    end
  end

  assign sclk_rise = sclk_s[SYNC_FF-2] & ~sclk_s[SYNC_FF-1];
  assign sclk_fall = ~sclk_s[SYNC_FF-2] & sclk_s[SYNC_FF-1];
  assign ss_rise   = ss_s[SYNC_FF-2] & ~ss_s[SYNC_FF-1];
  assign ss_fall   = ~ss_s[SYNC_FF-2] & ss_s[SYNC_FF-1];
  assign mosi_bit  = mosi_s[SYNC_FF-1];

  assign rx_byte   = {shift_in, mosi_bit};
  assign addr_next = (AUTOINC != 0) ? addr + 5'd1 : addr;
  // Select edges take priority over any sclk activity in the same cycle.
  assign active    = (state != IDLE) && !ss_rise && !ss_fall;
  assign byte_done = active && sclk_rise && (bit_cnt == 3'd7);
  assign spi_we    = byte_done && (state == DATA) && dir_wr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Deselect always wins; a reselect restarts at the command byte.
  always_comb begin
    state_next = state;
    if (ss_rise)                        state_next = IDLE;
    else if (ss_fall)                   state_next = CMD;
    else if (byte_done && state == CMD) state_next = DATA;
  end

  // Shifter and SPI-side outputs. shift_out holds the bits still to be
  // presented, so each sclk fall drives shift_out[7] and shifts; a freshly
  // loaded read byte therefore shows its bit 7 on the fall after the 8th rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= 3'd0;
      shift_in    <= 7'd0;
      shift_out   <= 8'h00;
      addr        <= 5'd0;
      dir_wr      <= 1'b0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 5'd0;
      wr_data_r   <= 8'h00;
    end else begin
      wr_strobe_r <= 1'b0;
      if (ss_rise) begin
        bit_cnt   <= 3'd0;
        miso_r    <= 1'b0;
        miso_oe_r <= 1'b0;
        busy_r    <= 1'b0;
      end else if (ss_fall) begin
        bit_cnt   <= 3'd0;
        shift_out <= {bus.status_in[6:0], 1'b0};
        miso_r    <= bus.status_in[7];
        miso_oe_r <= 1'b1;
        busy_r    <= 1'b1;
      end else if (active) begin
        if (sclk_rise) begin
          shift_in <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == CMD) begin
              addr      <= rx_byte[7:3];
              dir_wr    <= rx_byte[1];
              shift_out <= rx_byte[1] ? 8'h00 : regs[rx_byte[7:3]];
            end else begin
              addr <= addr_next;
              if (dir_wr) begin
                wr_strobe_r <= 1'b1;
                wr_addr_r   <= addr;
                wr_data_r   <= rx_byte;
              end else begin
                shift_out <= regs[addr_next];
              end
            end
          end
        end else if (sclk_fall) begin
          miso_r    <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  // Register file; the SPI write is issued last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
      loc_rdata_r <= 8'h00;
    end else begin
      loc_rdata_r <= regs[bus.loc_addr];
      if (bus.loc_wr) regs[bus.loc_addr] <= bus.loc_wdata;
      if (spi_we)     regs[addr]         <= rx_byte;
    end
  end

`ifdef SPI_IRQ_EN
  logic irq_r;

  // Sticky write flag; a strobe in the same cycle as the clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)                                      irq_r <= 1'b0;
    else if (wr_strobe_r)                           irq_r <= 1'b1;
    else if (bus.loc_wr && bus.loc_addr == 5'h1F)   irq_r <= 1'b0;
  end

  assign bus.irq = irq_r;
`endif

  assign bus.spi_miso    = miso_r;
  assign bus.spi_miso_oe = miso_oe_r;
  assign bus.busy        = busy_r;
  assign bus.wr_strobe   = wr_strobe_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.loc_rdata   = loc_rdata_r;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_regfile
// Drives spi_slave_regfile as an SPI mode-0 master plus the local port.
// Expected miso bytes and expected write strobes are queued as stimulus is
// driven and compared as the DUT produces them. Define SPI_IRQ_EN to also
// exercise the irq flag.
// ---------------------------------------------------------------------------
module tb_spi_slave_regfile;
  localparam int HALF = 8;

  typedef struct {
    logic [7:0] tx;
    logic       chk;
    logic [7:0] exp;
  } seq_t;

  logic clk = 1'b0;
  logic reset;
  int   num_compared   = 0;
  int   num_mismatched = 0;

  logic [7:0]  mdl [32];
  seq_t        seq_q [$];
  logic [7:0]  miso_q [$];
  logic [12:0] strobe_q [$];
  logic        coll_late;
  logic [4:0]  coll_addr;
  logic [7:0]  coll_data;

  always #5 clk = ~clk;

  spi_slave_regfile_if bus ();

  spi_slave_regfile #(.AUTOINC(1), .SYNC_FF(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.wr_strobe) begin
      if (strobe_q.size() == 0) checkOutput("wr_strobe_unexpected", bus.wr_strobe, 0);
      else checkOutput("wr_strobe_addr_data", {bus.wr_addr, bus.wr_data}, strobe_q.pop_front());
    end
  end

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.loc_addr  = a;
    bus.loc_wdata = d;
    bus.loc_wr    = 1'b1;
    @(negedge clk);
    bus.loc_wr = 1'b0;
    mdl[a] = d;
  endtask

  task automatic loc_check(input logic [4:0] a, input string tag);
    @(negedge clk);
    bus.loc_addr = a;
    @(negedge clk);
    checkOutput(tag, bus.loc_rdata, mdl[a]);
  endtask

  task automatic add_byte(input logic [7:0] tx, input logic chk, input logic [7:0] exp);
    seq_t s;
    s.tx  = tx;
    s.chk = chk;
    s.exp = exp;
    seq_q.push_back(s);
  endtask

  // One SPI byte (or its first nbits). With coll set, a local write is held
  // across the DUT's byte-complete cycle to collide with the SPI write.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic coll,
                          output logic [7:0] rx);
    int n;
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = bus.spi_miso;
      if (i == 0 && coll) begin
        bus.loc_addr  = coll_addr;
        bus.loc_wdata = coll_data;
        bus.loc_wr    = 1'b1;
      end
      bus.spi_sclk = 1'b1;
      if (i == 0 && coll) begin
        n = 0;
        while (!bus.wr_strobe && n < 20) begin @(negedge clk); n++; end
        checkOutput("coll_strobe_seen", bus.wr_strobe, 1);
        if (coll_late) begin
          while (bus.wr_strobe && n < 20) begin @(negedge clk); n++; end
          checkOutput("coll_strobe_end", bus.wr_strobe, 0);
        end
        bus.loc_wr = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  // Runs the queued byte sequence as one select window.
  task automatic applyStimulus(input int last_bits, input logic coll);
    seq_t       s;
    logic [7:0] rx;
    int         n;
    bus.spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    checkOutput("busy_selected", bus.busy, 1);
    checkOutput("miso_oe_selected", bus.spi_miso_oe, 1);
    n = seq_q.size();
    for (int k = 0; k < n; k++) begin
      s = seq_q.pop_front();
      if (s.chk) miso_q.push_back(s.exp);
      spi_byte(s.tx, (k == n - 1) ? last_bits : 8, coll && (k == n - 1), rx);
      if (s.chk) checkOutput("miso_byte", rx, miso_q.pop_front());
    end
    repeat (HALF) @(negedge clk);
    bus.spi_ss_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("busy_deselected", bus.busy, 0);
    checkOutput("miso_oe_deselected", bus.spi_miso_oe, 0);
    checkOutput("miso_deselected", bus.spi_miso, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.spi_sclk  = 1'b0;
    bus.spi_ss_n  = 1'b1;
    bus.spi_mosi  = 1'b0;
    bus.status_in = 8'h81;
    bus.loc_addr  = 5'd0;
    bus.loc_wr    = 1'b0;
    bus.loc_wdata = 8'h00;
    coll_late     = 1'b0;
    coll_addr     = 5'd0;
    coll_data     = 8'h00;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_miso_oe", bus.spi_miso_oe, 0);
    checkOutput("reset_miso", bus.spi_miso, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_wr_strobe", bus.wr_strobe, 0);
    checkOutput("reset_wr_addr", bus.wr_addr, 0);
    checkOutput("reset_wr_data", bus.wr_data, 0);
`ifdef SPI_IRQ_EN
    checkOutput("reset_irq", bus.irq, 0);
`endif
    for (int a = 0; a < 32; a++) loc_check(a[4:0], "reset_reg");

    // Write 0xA5 to register 10; status byte comes back during the command.
    bus.status_in = 8'hC3;
    add_byte(8'h52, 1'b1, 8'hC3);
    add_byte(8'hA5, 1'b0, 8'h00);
    strobe_q.push_back({5'd10, 8'hA5});
    mdl[10] = 8'hA5;
    applyStimulus(8, 1'b0);
    loc_check(5'd10, "write_reg10");
`ifdef SPI_IRQ_EN
    checkOutput("irq_after_write", bus.irq, 1);
    loc_write(5'd31, 8'h00);
    checkOutput("irq_after_clear", bus.irq, 0);
`endif

    // Read register 4 (loaded locally) and then register 5 via auto-increment.
    bus.status_in = 8'h81;
    loc_write(5'd4, 8'h3C);
    add_byte(8'h20, 1'b1, 8'h81);
    add_byte(8'h00, 1'b1, 8'h3C);
    add_byte(8'h00, 1'b1, mdl[5]);
    applyStimulus(8, 1'b0);

    // Burst write starting at 31 wraps to register 0.
    add_byte(8'hFA, 1'b1, 8'h81);
    add_byte(8'h11, 1'b0, 8'h00);
    add_byte(8'h22, 1'b0, 8'h00);
    strobe_q.push_back({5'd31, 8'h11});
    strobe_q.push_back({5'd0, 8'h22});
    mdl[31] = 8'h11;
    mdl[0]  = 8'h22;
    applyStimulus(8, 1'b0);
    loc_check(5'd31, "wrap_reg31");
    loc_check(5'd0, "wrap_reg0");

    // Burst read across the same wrap point.
    add_byte(8'hF8, 1'b1, 8'h81);
    add_byte(8'h00, 1'b1, mdl[31]);
    add_byte(8'h00, 1'b1, mdl[0]);
    applyStimulus(8, 1'b0);

    // Abort after 5 data bits: register 7 keeps its local value, no strobe.
    loc_write(5'd7, 8'h77);
    add_byte(8'h3A, 1'b1, 8'h81);
    add_byte(8'hE0, 1'b0, 8'h00);
    applyStimulus(5, 1'b0);
    loc_check(5'd7, "abort_reg7");

    // SPI write and local write hit register 12 together: SPI data survives.
    coll_addr = 5'd12;
    coll_data = 8'hEE;
    add_byte(8'h62, 1'b1, 8'h81);
    add_byte(8'h5A, 1'b0, 8'h00);
    strobe_q.push_back({5'd12, 8'h5A});
    mdl[12] = 8'h5A;
    applyStimulus(8, 1'b1);
    loc_check(5'd12, "collide_same_reg12");

    // Local write to another register in the same cycle still lands.
    coll_addr = 5'd20;
    coll_data = 8'h44;
    add_byte(8'h6A, 1'b1, 8'h81);
    add_byte(8'h6B, 1'b0, 8'h00);
    strobe_q.push_back({5'd13, 8'h6B});
    mdl[13] = 8'h6B;
    mdl[20] = 8'h44;
    applyStimulus(8, 1'b1);
    loc_check(5'd13, "collide_diff_reg13");
    loc_check(5'd20, "collide_diff_reg20");

`ifdef SPI_IRQ_EN
    // irq clear (local write to 31) in the same cycle as wr_strobe: set wins.
    coll_addr = 5'd31;
    coll_data = 8'h99;
    coll_late = 1'b1;
    add_byte(8'h1A, 1'b1, 8'h81);
    add_byte(8'h33, 1'b0, 8'h00);
    strobe_q.push_back({5'd3, 8'h33});
    mdl[3]  = 8'h33;
    mdl[31] = 8'h99;
    applyStimulus(8, 1'b1);
    coll_late = 1'b0;
    checkOutput("irq_set_wins", bus.irq, 1);
    loc_check(5'd3, "irq_reg3");
`endif

    repeat (10) @(negedge clk);
    checkOutput("strobe_queue_drained", strobe_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
